muladdsub_cinreg_checker: RTL and testbench
===========================================

# muladdsub_cinreg_checker

- Self-checking stimulus/response engine for the MULTADDSUB18X18 hardware test with `REGCIN="REGISTER"` and all other stages bypassed.
- Generates pseudo-random operands and control strobes, drives them into the DUT, and reads back `z`.
- Compares `z` against an internal golden model of the carry-in register and arithmetic, then reports pass/fail plus first-failure diagnostics.
- Sits beside the DUT on the test board and is the only source of the DUT's inputs.

## Interface
- `NUM_VECTORS`, 4096: vectors per run, 1..65535.
- `SEED`, 32'hACE11234: LFSR load value, nonzero.
- `SETTLE_CYCLES`, 2: wait cycles for the DUT combinational path, ≥1.

- `clk`  in  1  single clock for checker and DUT.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  begin a run; sampled in IDLE or DONE only.
- `z`  in  54  DUT result.
- `a`, `b`  out  18 each  operands.
- `c`  out  54  addend.
- `is_signed`, `addsub`, `cin`  out  1 each  DUT controls.
- `cecin`, `rstcin`  out  3 each  CIN-register enable/reset vectors.
- `cepipe`, `rstpipe`, `cectrl`, `rstctrl`, `cec`, `rstc`  out  3 each  random; must have no effect in bypass mode.
- `strobe`  out  1  qualifies all DUT enables/resets.
- `busy`  out  1  run in progress.
- `done`  out  1  run finished; holds until next start.
- `pass`  out  1  valid with done; 1 iff `err_count` == 0.
- `err_count`  out  16  mismatching vectors.
- `fail_idx`  out  16  index of first mismatch.
- `fail_z`  out  54  `z` captured at first mismatch.

## Operation
- Reset: every output is 0, FSM is in IDLE, model `cin_q` = 0, LFSR = `SEED`.
- FSM states: IDLE → INIT → GEN → APPLY → STROBE → SETTLE → CHECK → (GEN | DONE). DONE → INIT on `start`.
- On `start`: clear `err_count`, `fail_idx` and `fail_z`, reload the LFSR with `SEED`, clear the vector index, set `busy`.
- INIT (1 cycle):
  - Drive `strobe`=1, `rstcin`=3'b111, `cecin`=0; all other outputs 0.
  - This forces the DUT CIN register (GSR disabled) and the model `cin_q` to 0.
  - Not counted as a vector.
- GEN (4 cycles):
  - Cycle k loads the LFSR word into `stim[32k+31:32k]`, then advances the LFSR one step.
  - LFSR: 32-bit Galois, mask 32'h80200003, shift right, XOR the mask when the LSB is 1.
  - Field map:
    - `a`=[17:0], `b`=[35:18], `c`=[89:36].
    - `is_signed`=[90], `addsub`=[91], `cin`=[92].
    - `cecin`=[95:93], `rstcin`=[98:96].
    - The six other 3-bit controls occupy [116:99], in port-list order.
  - DUT outputs stay at the previous vector's values during GEN, with `strobe`=0.
- APPLY: drive the new fields with `strobe`=0 for `SETTLE_CYCLES` cycles.
- STROBE: 1 cycle with `strobe`=1. At the closing edge the model updates:
  - if `&rstcin`, `cin_q` ← 0 (reset has priority);
  - else if `|cecin`, `cin_q` ← `cin`;
  - else `cin_q` holds.
- SETTLE: `SETTLE_CYCLES` cycles, `strobe`=0.
- Golden model arithmetic:
  - P = `a`×`b`, 36 bits, signed or unsigned per `is_signed`.
  - P is extended to 54 bits: sign extension if signed, zero extension otherwise.
  - expected = (`c` + (`addsub` ? −P : P) + `cin_q`) mod 2^54.
  - Example: `a`=18'h3FFFF, `b`=2, `c`=0, `addsub`=0, `cin_q`=1 gives 54'h3FFFFFFFFFFFFF when signed and 54'h0000000007FFFF when unsigned.
  - Example: `a`=3, `b`=5, `c`=100, `addsub`=1, `cin_q`=0 gives 85.
- CHECK (1 cycle):
  - If `z` ≠ expected: increment `err_count`, saturating at 16'hFFFF.
  - If this is the first error of the run, also capture `fail_idx` = vector index and `fail_z` = `z`.
  - Then increment the index. Go to DONE when the index reaches `NUM_VECTORS`, else go to GEN.
- DONE:
  - `busy`=0, `done`=1, `pass` valid, `strobe`=0.
  - Operand outputs hold their last values.
- `start` while `busy` is ignored.
- Reset mid-run:
  - Immediate return to the reset state; all outputs 0.
  - A following `start` reproduces the identical stimulus sequence.

## Timing
- A vector takes 6 + 2×`SETTLE_CYCLES` cycles.
- A run takes 1 + `NUM_VECTORS`×(6 + 2×`SETTLE_CYCLES`) cycles from the edge sampling `start` to the edge setting `done`.
- With defaults that is 40961 cycles.
- `strobe` is high for exactly 1 cycle per vector, plus 1 cycle in INIT.
- `z` is sampled `SETTLE_CYCLES` cycles after the strobe edge.
- Expected-value logic may be registered. It must be stable by CHECK.

## Test plan
- Ideal behavioural DUT in the bench, `NUM_VECTORS`=16, `SETTLE_CYCLES`=2, `start` pulse → `done` rises 161 cycles later; `pass`=1, `err_count`=0, `strobe` high 17 times.
- Bench XORs `z[0]` only during vector 5 → `err_count`=1, `fail_idx`=5, `fail_z` = model^1, `pass`=0.
- Bench DUT with CIN register stuck at 0 → `err_count` equals the number of vectors whose model `cin_q`=1 (bench computes this independently); `fail_idx` is the first such vector.
- Bench model forced to the directed operands (`a`=3FFFF, `b`=2, `c`=0, `addsub`=0, `cin_q`=1, signed, then unsigned) → comparator accepts 54'h3FFFFFFFFFFFFF and 54'h7FFFF respectively, and rejects each off by one.
- `rst` asserted in vector 7's SETTLE → all outputs 0 asynchronously; restart → vector 0 fields bit-identical to the first run's.
- `start` pulsed while `busy` → no effect on the vector count or completion cycle.

Source files
------------

// File: rtl/muladdsub_cinreg_checker.sv
// muladdsub_cinreg_checker: LFSR stimulus engine and golden-model checker for a
// MULTADDSUB18X18 with only the carry-in register active.
module muladdsub_cinreg_checker #(
    parameter int          NUM_VECTORS   = 4096,
    parameter logic [31:0] SEED          = 32'hACE11234,
    parameter int          SETTLE_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [53:0] z,
    output logic [17:0] a,
    output logic [17:0] b,
    output logic [53:0] c,
    output logic        is_signed,
    output logic        addsub,
    output logic        cin,
    output logic [2:0]  cecin,
    output logic [2:0]  rstcin,
    output logic [2:0]  cepipe,
    output logic [2:0]  rstpipe,
    output logic [2:0]  cectrl,
    output logic [2:0]  rstctrl,
    output logic [2:0]  cec,
    output logic [2:0]  rstc,
    output logic        strobe,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] err_count,
    output logic [15:0] fail_idx,
    output logic [53:0] fail_z
);
    typedef enum logic [2:0] {IDLE, INIT, GEN, APPLY, STROBE, SETTLE, CHECK, DONE} state_t;
    state_t state, state_nx;
    logic [31:0]  lfsr, lfsr_nx;
    logic [95:0]  stim;
    logic [116:0] drv;
    logic [15:0]  cnt, idx;
    logic         cin_q, last;
    logic [35:0]  op_a, op_b, prod;
    logic [53:0]  p, expected;

    assign a         = drv[17:0];
    assign b         = drv[35:18];
    assign c         = drv[89:36];
    assign is_signed = drv[90];
    assign addsub    = drv[91];
    assign cin       = drv[92];
    assign cecin     = drv[95:93];
    assign rstcin    = state == INIT ? 3'b111 : drv[98:96];
    assign cepipe    = drv[101:99];
    assign rstpipe   = drv[104:102];
    assign cectrl    = drv[107:105];
    assign rstctrl   = drv[110:108];
    assign cec       = drv[113:111];
    assign rstc      = drv[116:114];
    assign strobe    = state == INIT || state == STROBE;
    assign busy      = state != IDLE && state != DONE;
    assign done      = state == DONE;
    assign pass      = done && err_count == 16'd0;
    assign last      = cnt == 16'(SETTLE_CYCLES - 1);
    assign lfsr_nx   = (lfsr >> 1) ^ (lfsr[0] ? 32'h80200003 : 32'h0);

    // One multiplier serves both modes: low 36 bits of the extended product are exact.
    always_comb begin
        op_a     = is_signed ? {{18{a[17]}}, a} : {18'b0, a};
        op_b     = is_signed ? {{18{b[17]}}, b} : {18'b0, b};
        prod     = op_a * op_b;
        p        = {(is_signed ? {18{prod[35]}} : 18'b0), prod};
        expected = c + (addsub ? ~p + 54'd1 : p) + {53'b0, cin_q};
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE, DONE: state_nx = start ? INIT : state;
            INIT:       state_nx = GEN;
            GEN:        state_nx = cnt[1:0] == 2'd3 ? APPLY : GEN;
            APPLY:      state_nx = last ? STROBE : APPLY;
            STROBE:     state_nx = SETTLE;
            SETTLE:     state_nx = last ? CHECK : SETTLE;
            CHECK:      state_nx = idx == 16'(NUM_VECTORS - 1) ? DONE : GEN;
            default:    state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            lfsr      <= SEED;
            stim      <= '0;
            drv       <= '0;
            cnt       <= '0;
            idx       <= '0;
            cin_q     <= 1'b0;
            err_count <= '0;
            fail_idx  <= '0;
            fail_z    <= '0;
        end else begin
            state <= state_nx;
            cnt   <= state_nx != state ? 16'd0 : cnt + 16'd1;
            case (state)
                IDLE, DONE: if (start) begin
                    lfsr      <= SEED;
                    drv       <= '0;
                    idx       <= '0;
                    err_count <= '0;
                    fail_idx  <= '0;
                    fail_z    <= '0;
                end
                INIT: cin_q <= 1'b0;
                GEN: begin
                    lfsr <= lfsr_nx;
                    stim <= {lfsr, stim[95:32]};
                    if (cnt[1:0] == 2'd3)
                        drv <= {lfsr[20:0], stim};
                end
                STROBE: cin_q <= &rstcin ? 1'b0 : (|cecin ? cin : cin_q);
                CHECK: begin
                    if (z != expected) begin
                        err_count <= &err_count ? err_count : err_count + 16'd1;
                        if (err_count == 16'd0) begin
                            fail_idx <= idx;
                            fail_z   <= z;
                        end
                    end
                    idx <= idx + 16'd1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_muladdsub_cinreg_checker.sv
// tb_muladdsub_cinreg_checker: behavioural MULTADDSUB18X18 (CIN register only) with
// fault modes, an LFSR stimulus scoreboard and end-of-run result checks.
module tb_muladdsub_cinreg_checker;
    localparam int          NV   = 16;
    localparam int          SC   = 2;
    localparam logic [31:0] SEED = 32'hACE11234;

    logic        clk = 1'b0, rst = 1'b1, start = 1'b0;
    logic [53:0] z;
    logic [17:0] a, b;
    logic [53:0] c;
    logic        is_signed, addsub, cin, strobe, busy, done, pass;
    logic [2:0]  cecin, rstcin, cepipe, rstpipe, cectrl, rstctrl, cec, rstc;
    logic [15:0] err_count, fail_idx;
    logic [53:0] fail_z;

    muladdsub_cinreg_checker #(.NUM_VECTORS(NV), .SEED(SEED), .SETTLE_CYCLES(SC)) dut (
        .clk(clk), .rst(rst), .start(start), .z(z), .a(a), .b(b), .c(c),
        .is_signed(is_signed), .addsub(addsub), .cin(cin), .cecin(cecin), .rstcin(rstcin),
        .cepipe(cepipe), .rstpipe(rstpipe), .cectrl(cectrl), .rstctrl(rstctrl),
        .cec(cec), .rstc(rstc), .strobe(strobe), .busy(busy), .done(done), .pass(pass),
        .err_count(err_count), .fail_idx(fail_idx), .fail_z(fail_z)
    );

    always #5 clk = ~clk;

    int           errors = 0, checks = 0;
    int           mode = 0, cur_vec = -1;
    logic         dcin = 1'b0;
    logic [116:0] exp_q[$];
    logic [53:0]  exp_z[NV];
    logic [116:0] v0_first, v0_last;

    function automatic logic [53:0] golden(input logic [17:0] fa, fb, input logic [53:0] fc,
                                           input logic sg, sub, ci);
        longint pa, pb, r;
        pa = sg ? longint'($signed(fa)) : longint'(fa);
        pb = sg ? longint'($signed(fb)) : longint'(fb);
        r  = sub ? longint'(fc) - pa * pb : longint'(fc) + pa * pb;
        r  = r + longint'(ci);
        return r[53:0];
    endfunction

    function automatic logic [31:0] step(input logic [31:0] x);
        return x[0] ? (x >> 1) ^ 32'h80200003 : x >> 1;
    endfunction

    // Behavioural DUT: mode 1 flips z[0] on vector 5, mode 2 sticks the CIN register
    // at 0, mode 3 adds +1 on vector 2 and -1 on vector 9.
    always_ff @(posedge clk)
        if (strobe) dcin <= &rstcin ? 1'b0 : (|cecin ? cin : dcin);

    always_comb begin
        z = golden(a, b, c, is_signed, addsub, mode == 2 ? 1'b0 : dcin);
        if (mode == 1 && cur_vec == 5) z = z ^ 54'd1;
        if (mode == 3 && cur_vec == 2) z = z + 54'd1;
        if (mode == 3 && cur_vec == 9) z = z - 54'd1;
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [116:0] fields();
        return {rstc, cec, rstctrl, cectrl, rstpipe, cepipe, rstcin, cecin, cin, addsub,
                is_signed, c, b, a};
    endfunction

    function automatic logic [127:0] status();
        return 128'({strobe, busy, done, pass, err_count, fail_idx, fail_z});
    endfunction

    task automatic run(input int md, input int abort_at, input int mid_at);
        logic [31:0]  l;
        logic [127:0] s;
        logic         mcin;
        int           k, strobes, ncin1, first1;
        mode = md;
        exp_q.delete();
        l = SEED;
        for (int v = 0; v < NV; v++) begin
            for (int w = 0; w < 4; w++) begin
                s[w*32 +: 32] = l;
                l = step(l);
            end
            exp_q.push_back(s[116:0]);
        end
        k = -1; strobes = 0; ncin1 = 0; first1 = -1; mcin = 1'b0;
        @(negedge clk);
        start = 1'b1;
        for (int it = 0; it < 400; it++) begin
            @(posedge clk);
            k++;
            @(negedge clk);
            start = 1'b0;
            if (strobe) begin
                strobes++;
                if (strobes == 1) begin
                    chk("init_drive", 128'(fields()), 128'({3'b000, 6'b0, 6'b0, 6'b0, 3'b111, 3'b000, 93'b0}));
                    mcin = 1'b0;
                    cur_vec = -1;
                end else begin
                    int v = strobes - 2;
                    if (exp_q.size() == 0) chk("extra_vector", 128'(v), 128'(NV));
                    else chk($sformatf("fields_v%0d", v), 128'(fields()), 128'(exp_q.pop_front()));
                    if (v == 0) v0_last = fields();
                    mcin = &rstcin ? 1'b0 : (|cecin ? cin : mcin);
                    if (v < NV) exp_z[v] = golden(a, b, c, is_signed, addsub, mcin);
                    if (mcin) begin
                        ncin1++;
                        if (first1 < 0) first1 = v;
                    end
                    cur_vec = v;
                    if (v == mid_at) start = 1'b1;
                    if (v == abort_at) begin
                        @(posedge clk);
                        #2 rst = 1'b1;
                        #1;
                        chk("abort_fields", 128'(fields()), 128'(0));
                        chk("abort_status", status(), 128'(0));
                        @(negedge clk);
                        @(negedge clk);
                        rst = 1'b0;
                        return;
                    end
                end
            end
            if (done) break;
        end
        chk("done_cycle", 128'(k), 128'(1 + NV * (6 + 2 * SC)));
        chk("strobe_count", 128'(strobes), 128'(NV + 1));
        chk("done_busy", 128'({done, busy}), 128'(2'b10));
        case (md)
            1: begin
                chk("m1_errs", 128'({pass, err_count, fail_idx}), 128'({1'b0, 16'd1, 16'd5}));
                chk("m1_fail_z", 128'(fail_z), 128'(exp_z[5] ^ 54'd1));
            end
            2: begin
                chk("m2_errs", 128'({pass, err_count}), 128'({ncin1 == 0, 16'(ncin1)}));
                if (first1 >= 0) begin
                    chk("m2_fail_idx", 128'(fail_idx), 128'(first1));
                    chk("m2_fail_z", 128'(fail_z), 128'(exp_z[first1] - 54'd1));
                end
            end
            3: begin
                chk("m3_errs", 128'({pass, err_count, fail_idx}), 128'({1'b0, 16'd2, 16'd2}));
                chk("m3_fail_z", 128'(fail_z), 128'(exp_z[2] + 54'd1));
            end
            default: chk("ideal_result", 128'({pass, err_count, fail_idx, fail_z}), 128'({1'b1, 86'b0}));
        endcase
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_fields", 128'(fields()), 128'(0));
        chk("reset_status", status(), 128'(0));
        rst = 1'b0;
        chk("golden_signed", 128'(golden(18'h3FFFF, 18'd2, 54'd0, 1'b1, 1'b0, 1'b1)), 128'(54'h3FFFFFFFFFFFFF));
        chk("golden_unsigned", 128'(golden(18'h3FFFF, 18'd2, 54'd0, 1'b0, 1'b0, 1'b1)), 128'(54'h7FFFF));
        chk("golden_sub", 128'(golden(18'd3, 18'd5, 54'd100, 1'b0, 1'b1, 1'b0)), 128'(54'd85));
        run(0, -1, -1);
        v0_first = v0_last;
        run(1, -1, -1);
        run(2, -1, -1);
        run(3, -1, -1);
        run(0, -1, 4);
        run(0, 7, -1);
        run(0, -1, -1);
        chk("restart_v0", 128'(v0_last), 128'(v0_first));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
